inst_mem_loader: RTL

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader.sv | 131 +++++++++++++
 1 files changed

// File: rtl/inst_mem_loader.sv
// rtl/inst_mem_loader.sv - byte-stream loader that writes 32-bit program words into instruction memory
module inst_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [7:0]        byte_i,
    input  logic              byte_valid_i,
    output logic              byte_ready_o,
    output logic              WE_o,
    output logic [ADDR_W-1:0] AddrW_o,
    output logic [DATA_W-1:0] DataW_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o
);

    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR} state_t;

    localparam logic [16:0] DEPTH = 17'd1 << ADDR_W;

    state_t            state, nextState;
    logic [15:0]       lenN;
    logic [15:0]       wordCnt;
    logic [ADDR_W-1:0] addrReg;
    logic [1:0]        byteIdx;
    logic [23:0]       shiftReg;
    logic              accept;
    logic              startTaken;
    logic [15:0]       fullLen;

    assign accept     = byte_valid_i && byte_ready_o;
    assign startTaken = start_i && (state == IDLE || state == DONE || state == ERR);
    assign fullLen    = {byte_i, lenN[7:0]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        byte_ready_o = 1'b0;
        cpu_hold_o   = 1'b0;
        done_o       = 1'b0;
        err_o        = 1'b0;
        WE_o         = 1'b0;
        case (state)
            IDLE: if (start_i) nextState = LEN0;
            LEN0: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
                if (accept) nextState = LEN1;
            end
            LEN1: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
                if (accept) begin
                    if (fullLen == 16'd0)               nextState = DONE;
                    else if ({1'b0, fullLen} > DEPTH)   nextState = ERR;
                    else                                nextState = DATA;
                end
            end
            DATA: begin
                byte_ready_o = 1'b1;
                cpu_hold_o   = 1'b1;
                if (accept && byteIdx == 2'd3) nextState = WRITE;
            end
            WRITE: begin
                cpu_hold_o = 1'b1;
                WE_o       = 1'b1;
                nextState  = (16'(wordCnt + 16'd1) == lenN) ? DONE : DATA;
            end
            DONE: begin
                done_o = 1'b1;
                if (start_i) nextState = LEN0;
            end
            ERR: begin
                err_o      = 1'b1;
                cpu_hold_o = 1'b1;
                if (start_i) nextState = LEN0;
            end
            default: nextState = IDLE;
        endcase
    end

    // Write address/data are captured on the 4th byte so they stay stable through WRITE and after it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lenN     <= '0;
            wordCnt  <= '0;
            addrReg  <= '0;
            byteIdx  <= '0;
            shiftReg <= '0;
            AddrW_o  <= '0;
            DataW_o  <= '0;
        end else if (startTaken) begin
            lenN    <= '0;
            wordCnt <= '0;
            addrReg <= '0;
            byteIdx <= '0;
        end else begin
            case (state)
                LEN0: if (accept) lenN[7:0]  <= byte_i;
                LEN1: if (accept) lenN[15:8] <= byte_i;
                DATA: begin
                    if (accept) begin
                        byteIdx <= byteIdx + 2'd1;
                        if (byteIdx == 2'd3) begin
                            DataW_o <= DATA_W'({byte_i, shiftReg});
                            AddrW_o <= addrReg;
                        end else begin
                            shiftReg <= {byte_i, shiftReg[23:8]};
                        end
                    end
                end
                WRITE: begin
                    addrReg <= addrReg + 1'b1;
                    wordCnt <= wordCnt + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
